// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: registered request/response data-bus fabric between the
// CPU data port and NUM_SLAVES memory-mapped slaves. Mask/base decode with
// lowest-index priority, one outstanding transaction, and an error response
// for unmapped addresses.
// Optional feature macro: BUS_TIMEOUT_EN (WAIT-state watchdog bounded by TIMEOUT).
module soc_bus_fabric #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE =
    {32'h8000_0000, 32'h1000_0000, 32'h0C00_0000, 32'h0200_0000},
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK =
    {32'hF000_0000, 32'hFFFF_FFE0, 32'hFC00_0000, 32'hFFFF_0000},
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             mem_addr,
  input  logic [31:0]             mem_wdata,
  input  logic [3:0]              mem_wstrb,
  input  logic                    mem_rstrb,
  output logic [31:0]             mem_rdata,
  output logic                    mem_ready,
  output logic                    mem_err,
  output logic [31:0]             s_addr,
  output logic [31:0]             s_wdata,
  output logic [4*NUM_SLAVES-1:0] s_wstrb,
  output logic [NUM_SLAVES-1:0]   s_rstrb,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]   s_ready,
  output logic [15:0]             err_count
);

  localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                  state;
  logic [SEL_W-1:0]        sel;
  logic                    is_read;

  logic                    req;
  logic                    is_write;
  logic                    hit;
  logic [SEL_W-1:0]        hit_sel;
  logic [NUM_SLAVES-1:0]   rstrb_fan;
  logic [4*NUM_SLAVES-1:0] wstrb_fan;
  logic [31:0]             sel_rdata;
  logic                    sel_ready;

`ifdef BUS_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wait_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^16'(TIMEOUT);
`endif

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Address decode of the incoming request; descending scan so the lowest hit wins
  always_comb begin
    req       = mem_rstrb | (|mem_wstrb);
    is_write  = |mem_wstrb;
    hit       = 1'b0;
    hit_sel   = '0;
    rstrb_fan = '0;
    wstrb_fan = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((mem_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        hit     = 1'b1;
        hit_sel = SEL_W'(i);
      end
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (hit && (hit_sel == SEL_W'(i))) begin
        rstrb_fan[i]       = ~is_write;
        wstrb_fan[4*i +: 4] = mem_wstrb;
      end
    end
  end

  // Select ready/rdata of the slave owning the current transaction
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[32*i +: 32];
      end
    end
  end

  // Transaction FSM with registered slave strobes and master response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      is_read   <= 1'b0;
      mem_rdata <= '0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      s_rstrb   <= '0;
      err_count <= '0;
`ifdef BUS_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
      s_wstrb   <= '0;
      s_rstrb   <= '0;
      case (state)
        IDLE: begin
          if (req) begin
            s_addr  <= mem_addr;
            s_wdata <= mem_wdata;
            is_read <= ~is_write;
            if (hit) begin
              sel     <= hit_sel;
              s_rstrb <= rstrb_fan;
              s_wstrb <= wstrb_fan;
              state   <= ISSUE;
`ifdef BUS_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end else begin
              mem_ready <= 1'b1;
              mem_err   <= 1'b1;
              err_count <= sat_inc(err_count);
              state     <= RESP;
            end
          end
        end
        ISSUE, WAIT: begin
          if (sel_ready) begin
            mem_ready <= 1'b1;
            mem_rdata <= is_read ? sel_rdata : 32'd0;
            state     <= RESP;
          end
`ifdef BUS_TIMEOUT_EN
          else if ((state == WAIT) && (wait_cnt == WAIT_LAST)) begin
            mem_ready <= 1'b1;
            mem_err   <= 1'b1;
            err_count <= sat_inc(err_count);
            state     <= RESP;
          end else begin
            if (state == WAIT) wait_cnt <= wait_cnt + 16'd1;
            state <= WAIT;
          end
`else
          else begin
            state <= WAIT;
          end
`endif
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Self-checking bench for soc_bus_fabric: a driver pushes expected responses
// (data, error flag, response cycle) into a queue, a monitor pops and compares
// on every mem_ready, and a behavioural slave model answers with per-slave latency.
`timescale 1ns/1ps
module tb_soc_bus_fabric;

  localparam int NS  = 4;
  localparam int TMO = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic [3:0]    mem_wstrb = '0;
  logic          mem_rstrb = 1'b0;
  logic [31:0]   mem_rdata;
  logic          mem_ready;
  logic          mem_err;
  logic [31:0]   s_addr;
  logic [31:0]   s_wdata;
  logic [4*NS-1:0] s_wstrb;
  logic [NS-1:0] s_rstrb;
  logic [32*NS-1:0] s_rdata = '0;
  logic [NS-1:0] rdy_m = '0;
  logic [NS-1:0] stray = '0;
  logic [NS-1:0] s_ready;
  logic [15:0]   err_count;

  assign s_ready = rdy_m | stray;

  soc_bus_fabric #(.NUM_SLAVES(NS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rstrb(mem_rstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rstrb(s_rstrb),
    .s_rdata(s_rdata), .s_ready(s_ready), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   lat [NS];
  int   exp_errs = 0;
  exp_t sb [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Independent address map of the default configuration
  function automatic int ref_decode(input logic [31:0] a);
    if (a[31:16] == 16'h0200)             return 0;
    else if (a[31:26] == 6'b000011)       return 1;
    else if (a[31:5] == 27'h080_0000)     return 2;
    else if (a[31:28] == 4'h8)            return 3;
    else                                  return -1;
  endfunction

  function automatic logic [31:0] slave_data(input int i);
    logic [31:0] d;
    d = s_rdata[32*i +: 32];
    return d;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural slaves: ready after lat[i] cycles counted from the strobe cycle
  initial begin : slave_model
    int act;
    int cnt;
    act = -1;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      rdy_m = '0;
      if (rst) begin
        act = -1;
      end else begin
        for (int i = 0; i < NS; i++)
          if (s_rstrb[i] || (|s_wstrb[4*i +: 4])) begin
            act = i;
            cnt = lat[i];
          end
        if (act >= 0) begin
          if (cnt == 0) begin
            rdy_m[act] = 1'b1;
            act = -1;
          end else if (cnt > 0) begin
            cnt--;
          end
        end
      end
    end
  end

  // Response monitor: every mem_ready must match the head of the scoreboard
  initial forever begin
    @(posedge clk);
    #1;
    if (mem_ready && !rst) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 64'(mem_ready), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rdata", 64'(mem_rdata), 64'(e.rdata));
        check("err", 64'(mem_err), 64'(e.err));
        check("resp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Build the expected response for a request presented in the current cycle
  task automatic push_expect(input logic [31:0] a, input logic [3:0] ws, input int p);
    exp_t e;
    int s;
    s = ref_decode(a);
    if (s < 0) begin
      e.rdata = 32'd0; e.err = 1'b1; e.cyc = p;
      exp_errs++;
    end else if (lat[s] < 0) begin
      e.rdata = 32'd0; e.err = 1'b1; e.cyc = p + 1 + TMO;
      exp_errs++;
    end else begin
      e.rdata = (ws != 4'd0) ? 32'd0 : slave_data(s);
      e.err = 1'b0;
      e.cyc = p + 1 + lat[s];
    end
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while (sb.size() > 0 && b < 100) begin
      @(posedge clk);
      #2;
      b++;
    end
    if (sb.size() > 0) begin
      check("resp_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, input logic rs);
    int s;
    int p;
    logic [NS-1:0]   er;
    logic [4*NS-1:0] ew;
    s = ref_decode(a);
    er = '0;
    ew = '0;
    if (s >= 0) begin
      if (ws != 4'd0) ew[4*s +: 4] = ws;
      else            er[s] = 1'b1;
    end
    @(negedge clk);
    mem_addr = a; mem_wdata = wd; mem_wstrb = ws; mem_rstrb = rs;
    p = cyc + 1;
    push_expect(a, ws, p);
    @(posedge clk);
    #1;
    mem_wstrb = '0; mem_rstrb = 1'b0;
    check("rstrb_c1", 64'(s_rstrb), 64'(er));
    check("wstrb_c1", 64'(s_wstrb), 64'(ew));
    check("s_addr", 64'(s_addr), 64'(a));
    if (ws != 4'd0) check("s_wdata", 64'(s_wdata), 64'(wd));
    @(posedge clk);
    #1;
    check("rstrb_c2", 64'(s_rstrb), 64'd0);
    check("wstrb_c2", 64'(s_wstrb), 64'd0);
    wait_drain();
    check("err_count", 64'(err_count), 64'(exp_errs));
    @(negedge clk);
  endtask

  initial begin
    int p;
    for (int i = 0; i < NS; i++) lat[i] = i;
    s_rdata[31:0]   = 32'hA0A0_0000;
    s_rdata[63:32]  = 32'hB1B1_1111;
    s_rdata[95:64]  = 32'hC2C2_2222;
    s_rdata[127:96] = 32'h1234_5678;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(mem_ready), 64'd0);
    check("rst_rdata", 64'(mem_rdata), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_err", 64'(mem_err), 64'd0);
    check("rst_strb", 64'({s_rstrb, s_wstrb}), 64'd0);
    check("rst_addr", 64'({s_addr, s_wdata}), 64'd0);
    check("rst_errcnt", 64'(err_count), 64'd0);

    // Zero-wait read, then 3-wait write, then unmapped read
    lat[3] = 0;
    txn(32'h8000_0010, 32'h0, 4'b0000, 1'b1);
    lat[2] = 3;
    txn(32'h1000_0004, 32'hDEAD_BEEF, 4'b0011, 1'b0);
    txn(32'h4000_0000, 32'h0, 4'b0000, 1'b1);

    // Other slaves and latencies; read+write strobes together is a write
    lat[0] = 1;
    txn(32'h0200_0040, 32'h0, 4'b0000, 1'b1);
    lat[1] = 2;
    txn(32'h0C12_3456, 32'h0, 4'b0000, 1'b1);
    txn(32'h0200_0000, 32'h5555_AAAA, 4'b1000, 1'b1);
    txn(32'h1000_0020, 32'h0, 4'b1111, 1'b0);
    lat[2] = 5;
    txn(32'h1000_001C, 32'h0, 4'b0000, 1'b1);

    // Second request held during WAIT is ignored, accepted once reasserted
    lat[2] = 3;
    @(negedge clk);
    mem_addr = 32'h1000_0008; mem_wdata = 32'h0BAD_F00D; mem_wstrb = 4'b1111;
    p = cyc + 1;
    push_expect(32'h1000_0008, 4'b1111, p);
    @(negedge clk);
    mem_wstrb = '0;
    @(negedge clk);
    mem_addr = 32'h4000_0000; mem_rstrb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_rstrb = 1'b0;
    wait_drain();
    repeat (4) @(negedge clk);
    check("held_errcnt", 64'(err_count), 64'(exp_errs));
    txn(32'h4000_0000, 32'h0, 4'b0000, 1'b1);

`ifdef BUS_TIMEOUT_EN
    // Slave that never answers times out; a late stray ready is ignored
    lat[1] = -1;
    txn(32'h0C00_0000, 32'h0, 4'b0000, 1'b1);
    stray[1] = 1'b1;
    @(negedge clk);
    stray[1] = 1'b0;
    repeat (4) @(negedge clk);
    check("stray_errcnt", 64'(err_count), 64'(exp_errs));
`endif

    // Reset pulsed in WAIT aborts the transaction
    lat[1] = -1;
    @(negedge clk);
    mem_addr = 32'h0C00_0100; mem_rstrb = 1'b1;
    @(negedge clk);
    mem_rstrb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'({mem_ready, mem_err}), 64'd0);
    check("mid_rst_strb", 64'({s_rstrb, s_wstrb}), 64'd0);
    check("mid_rst_addr", 64'({s_addr, s_wdata}), 64'd0);
    check("mid_rst_errcnt", 64'(err_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_errs = 0;
    sb.delete();
    lat[1] = 1;
    txn(32'h0C00_0100, 32'h0, 4'b0000, 1'b1);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
